octree_bfs_engine: RTL and testbench
====================================

// Module: octree_bfs_engine
// PURPOSE
//  Parametrised breadth-first traversal engine for the octree branch table in BRAM.
//  - Starts at ROOT_ADDR and reads one node word per visit.
//  - Emits the node's 8-bit occupancy code, packed MSB-first into BURST_W bursts for the DDR writer.
//  - Enqueues unvisited branch children into a circular FIFO queue.
//  - Adds a visited bitmap checked at push time, a valid/ready output, overflow/range error flags and a node limit.
// PARAMETERS
//  ADDR_W        9    BRAM address width; the visited bitmap holds 2**ADDR_W bits
//  PTR_W         16   child pointer field width
//  NODE_W        152  BRAM word width; child fields occupy [NODE_W-1 -: 8*PTR_W]
//  QUEUE_DEPTH   512  FIFO entries, power of 2, >= 4
//  BURST_W       64   output burst width, multiple of 8; BYTES = BURST_W/8
//  BRAM_LATENCY  1    cycles from o_bram_en to valid i_bram_dout, 1..3
//  ROOT_ADDR     2    root node address
// PORTS
//  i_clk          in   1                 clock
//  i_rst          in   1                 reset, asynchronous active-low
//  i_start        in   1                 start pulse; accepted only in IDLE
//  i_node_limit   in   16                maximum nodes to emit; 0 = unlimited
//  o_bram_en      out  1                 BRAM read enable
//  o_bram_addr    out  ADDR_W            BRAM read address
//  i_bram_dout    in   NODE_W            BRAM read data
//  o_occ_data     out  BURST_W           packed occupancy codes; first code in [BURST_W-1 -: 8]
//  o_occ_valid    out  1                 burst valid
//  i_occ_ready    in   1                 sink ready
//  o_occ_last     out  1                 marks the final burst of a traversal
//  o_occ_bytes    out  clog2(BYTES+1)    number of valid bytes in this burst
//  o_busy         out  1                 high from start accept until DONE
//  o_done         out  1                 one-cycle pulse when the last burst handshakes
//  o_node_count   out  16                nodes emitted in this traversal
//  o_overflow     out  1                 sticky: a push was attempted while the queue was full
//  o_range_err    out  1                 sticky: a child pointer was >= 2**ADDR_W
// BEHAVIOUR
//  Reset: every output is 0, the FSM is in IDLE, and the queue, pack register and visited bitmap are cleared.
//  Reset may assert at any cycle, including mid-traversal; no output, flag or count survives it.
//  Child field encoding:
//  - Field j is [NODE_W-1-j*PTR_W -: PTR_W], j = 0..7; it drives occupancy bit 7-j.
//  - Pointer 0 = empty slot (occ bit 0). Pointer 1 = leaf (occ bit 1, not enqueued). Pointer >= 2 = branch (occ bit 1).
//  FSM states: IDLE, FETCH, WAIT, EMIT, PUSH, FLUSH, DONE.
//  - IDLE: on i_start, clear bitmap, queue, pack register, o_node_count and sticky flags.
//    Mark ROOT_ADDR visited, enqueue it, assert o_busy, go to FETCH.
//  - FETCH: pop the queue head, drive o_bram_addr = head and o_bram_en = 1 for one cycle, go to WAIT.
//  - WAIT: hold BRAM_LATENCY cycles, then register i_bram_dout into the node register, go to EMIT.
//  - EMIT: write the occupancy byte at slot byte_cnt, byte_cnt++, o_node_count++.
//    When byte_cnt reaches BYTES, assert o_occ_valid with o_occ_last = 0 and o_occ_bytes = BYTES.
//    If the previous burst is still valid and not yet accepted, stall in EMIT; nothing is overwritten.
//  - PUSH: one field per cycle, j = 0..7 (8 cycles).
//    Enqueue the field if ptr >= 2, ptr < 2**ADDR_W and not visited; set its visited bit in the same cycle.
//    If ptr >= 2**ADDR_W: set o_range_err and do not enqueue.
//    If the queue is full: set o_overflow, drop the entry and continue.
//  - After PUSH: go to FLUSH if the queue is empty, or if i_node_limit != 0 and o_node_count == i_node_limit. Otherwise go to FETCH.
//  - FLUSH: wait for any pending full burst to be accepted.
//    Then present the remaining bytes (zero-padded at the LSBs) with o_occ_last = 1 and o_occ_bytes = byte_cnt (0..BYTES-1).
//    A final burst with 0 bytes is still sent so every traversal ends with exactly one last burst.
//  - DONE: entered on the last handshake; pulse o_done, drop o_busy, return to IDLE.
//  Output handshake:
//  - A burst transfers on o_occ_valid & i_occ_ready.
//  - o_occ_data, o_occ_bytes and o_occ_last stay stable while valid and not ready. Valid never drops without a handshake.
//  Queue: head and tail pointers wrap modulo QUEUE_DEPTH. A separate count distinguishes full from empty. Push and pop never coincide.
//  Counters: o_node_count saturates at 16'hFFFF.
//  i_start outside IDLE is ignored. i_node_limit is sampled on start accept.
//  A duplicate pointer within a node or across nodes is enqueued exactly once.
// TESTING
//  1. Root fields all 1 -> one burst 0xFF00_0000_0000_0000, bytes = 1, last = 1; o_node_count = 1; o_done pulses.
//  2. Root fields 3,4,0,0,0,0,0,0; nodes 3 and 4 fields all 1 -> data 0xC0FF_FF00_0000_0000, bytes = 3, last = 1.
//  3. Root fields 3,3,3,0...; node 3 fields 2,1,0... -> codes E0,C0 only; 2 and 3 each visited once; node_count = 2.
//  4. QUEUE_DEPTH = 4; root has 8 distinct branch children -> o_overflow = 1; 4 children visited; traversal still completes with last.
//  5. 9-node tree with i_occ_ready low for 20 cycles after the first valid -> data held stable; 1 full + 1 last burst (bytes = 1).
//  6. Assert i_rst mid-PUSH -> all outputs 0 within the reset; a new i_start repeats test 2 with identical output.

Source files
------------

// File: rtl/octree_bfs_engine_if.sv
// BRAM read port and occupancy burst stream of the octree BFS engine.
// The engine drives the master side; the BRAM and the DDR writer sit on the slave side.
interface octree_bfs_engine_if #(
  parameter int ADDR_W  = 9,
  parameter int NODE_W  = 152,
  parameter int BURST_W = 64
);
  localparam int BYTES  = BURST_W / 8;
  localparam int BCNT_W = $clog2(BYTES + 1);

  logic                o_bram_en;
  logic [ADDR_W-1:0]   o_bram_addr;
  logic [NODE_W-1:0]   i_bram_dout;
  logic [BURST_W-1:0]  o_occ_data;
  logic                o_occ_valid;
  logic                i_occ_ready;
  logic                o_occ_last;
  logic [BCNT_W-1:0]   o_occ_bytes;

  modport master (
    output o_bram_en, o_bram_addr,
    input  i_bram_dout,
    output o_occ_data, o_occ_valid, o_occ_last, o_occ_bytes,
    input  i_occ_ready
  );

  modport slave (
    input  o_bram_en, o_bram_addr,
    output i_bram_dout,
    input  o_occ_data, o_occ_valid, o_occ_last, o_occ_bytes,
    output i_occ_ready
  );
endinterface

// File: rtl/octree_bfs_engine.sv
// Breadth-first walker over the octree branch table: fetches one node per visit,
// streams its occupancy byte in packed bursts and queues each unvisited branch child once.
module octree_bfs_engine #(
  parameter int ADDR_W       = 9,
  parameter int PTR_W        = 16,
  parameter int NODE_W       = 152,
  parameter int QUEUE_DEPTH  = 512,
  parameter int BURST_W      = 64,
  parameter int BRAM_LATENCY = 1,
  parameter int ROOT_ADDR    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [15:0]          i_node_limit,
  octree_bfs_engine_if.master  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [15:0]          o_node_count,
  output logic                 o_overflow,
  output logic                 o_range_err
);
  localparam int BYTES   = BURST_W / 8;
  localparam int BCNT_W  = $clog2(BYTES + 1);
  localparam int QPTR_W  = $clog2(QUEUE_DEPTH);
  localparam int MAP_N   = 2 ** ADDR_W;
  localparam int FIELD_W = 8 * PTR_W;

  localparam logic [1:0]        WAIT_LAST = 2'(BRAM_LATENCY - 1);
  localparam logic [QPTR_W:0]   Q_FULL    = (QPTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [BCNT_W-1:0] BYTES_C   = BCNT_W'(BYTES);
  localparam logic [ADDR_W-1:0] ROOT_C    = ADDR_W'(ROOT_ADDR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]          state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         node_count_q, node_count_d;
  logic                overflow_q, overflow_d;
  logic                range_err_q, range_err_d;
  logic [15:0]         node_limit_q, node_limit_d;
  logic [QPTR_W-1:0]   head_q, head_d;
  logic [QPTR_W-1:0]   tail_q, tail_d;
  logic [QPTR_W:0]     q_count_q, q_count_d;
  logic [MAP_N-1:0]    visited_q, visited_d;
  logic [FIELD_W-1:0]  node_q, node_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  logic [2:0]          field_idx_q, field_idx_d;
  logic [BURST_W-1:0]  pack_q, pack_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BURST_W-1:0]  occ_data_q, occ_data_d;
  logic                occ_valid_q, occ_valid_d;
  logic                occ_last_q, occ_last_d;
  logic [BCNT_W-1:0]   occ_bytes_q, occ_bytes_d;

  logic [ADDR_W-1:0]   queue_mem_q [QUEUE_DEPTH];
  logic                push_en;
  logic [QPTR_W-1:0]   push_idx;
  logic [ADDR_W-1:0]   push_addr;

  logic [7:0]          occ_byte;
  logic [PTR_W-1:0]    cur_ptr;
  logic [ADDR_W-1:0]   cur_addr;
  logic                ptr_branch;
  logic                ptr_in_range;
  logic                q_full;
  logic                out_free;
  logic [BURST_W-1:0]  pack_ins;

  // Spare low bits of the node word carry no child pointers.
  if (NODE_W > FIELD_W) begin : g_pad
    logic unused_pad_bits;
    assign unused_pad_bits = ^bus.i_bram_dout[NODE_W-FIELD_W-1:0];
  end

  always_comb begin
    occ_byte = '0;
    for (int j = 0; j < 8; j++) begin
      occ_byte[7-j] = |node_q[FIELD_W-1-j*PTR_W -: PTR_W];
    end
    cur_ptr      = node_q[FIELD_W-1-int'(field_idx_q)*PTR_W -: PTR_W];
    cur_addr     = cur_ptr[ADDR_W-1:0];
    ptr_branch   = cur_ptr >= PTR_W'(2);
    ptr_in_range = (cur_ptr >> ADDR_W) == '0;
    q_full       = q_count_q == Q_FULL;
    out_free     = !occ_valid_q || bus.i_occ_ready;
    pack_ins     = pack_q;
    pack_ins[BURST_W-1-8*int'(byte_cnt_q) -: 8] = occ_byte;
  end

  // Traversal FSM; the output burst register frees itself on every handshake.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    node_count_d = node_count_q;
    overflow_d   = overflow_q;
    range_err_d  = range_err_q;
    node_limit_d = node_limit_q;
    head_d       = head_q;
    tail_d       = tail_q;
    q_count_d    = q_count_q;
    visited_d    = visited_q;
    node_d       = node_q;
    wait_cnt_d   = wait_cnt_q;
    field_idx_d  = field_idx_q;
    pack_d       = pack_q;
    byte_cnt_d   = byte_cnt_q;
    occ_data_d   = occ_data_q;
    occ_valid_d  = occ_valid_q;
    occ_last_d   = occ_last_q;
    occ_bytes_d  = occ_bytes_q;
    push_en      = 1'b0;
    push_idx     = tail_q;
    push_addr    = '0;

    if (occ_valid_q && bus.i_occ_ready) begin
      occ_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          visited_d         = '0;
          visited_d[ROOT_C] = 1'b1;
          push_en           = 1'b1;
          push_idx          = '0;
          push_addr         = ROOT_C;
          head_d            = '0;
          tail_d            = QPTR_W'(1);
          q_count_d         = (QPTR_W + 1)'(1);
          pack_d            = '0;
          byte_cnt_d        = '0;
          node_count_d      = '0;
          overflow_d        = 1'b0;
          range_err_d       = 1'b0;
          node_limit_d      = i_node_limit;
          busy_d            = 1'b1;
          state_d           = S_FETCH;
        end
      end
      S_FETCH: begin
        head_d     = head_q + QPTR_W'(1);
        q_count_d  = q_count_q - (QPTR_W + 1)'(1);
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          node_d  = bus.i_bram_dout[NODE_W-1 -: FIELD_W];
          state_d = S_EMIT;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_EMIT: begin
        if (out_free) begin
          if (node_count_q != 16'hFFFF) begin
            node_count_d = node_count_q + 16'd1;
          end
          if (byte_cnt_q == BYTES_C - BCNT_W'(1)) begin
            occ_data_d  = pack_ins;
            occ_valid_d = 1'b1;
            occ_last_d  = 1'b0;
            occ_bytes_d = BYTES_C;
            pack_d      = '0;
            byte_cnt_d  = '0;
          end else begin
            pack_d     = pack_ins;
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
          field_idx_d = '0;
          state_d     = S_PUSH;
        end
      end
      S_PUSH: begin
        if (ptr_branch) begin
          if (!ptr_in_range) begin
            range_err_d = 1'b1;
          end else if (!visited_q[cur_addr]) begin
            if (q_full) begin
              overflow_d = 1'b1;
            end else begin
              push_en             = 1'b1;
              push_addr           = cur_addr;
              tail_d              = tail_q + QPTR_W'(1);
              q_count_d           = q_count_q + (QPTR_W + 1)'(1);
              visited_d[cur_addr] = 1'b1;
            end
          end
        end
        if (field_idx_q == 3'd7) begin
          if (q_count_d == '0 || (node_limit_q != 16'd0 && node_count_q == node_limit_q)) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          field_idx_d = field_idx_q + 3'd1;
        end
      end
      S_FLUSH: begin
        // Once the last burst is on the bus, only its handshake can finish the traversal.
        if (occ_valid_q && occ_last_q) begin
          if (bus.i_occ_ready) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end else if (out_free) begin
          occ_data_d  = pack_q;
          occ_valid_d = 1'b1;
          occ_last_d  = 1'b1;
          occ_bytes_d = byte_cnt_q;
          pack_d      = '0;
          byte_cnt_d  = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      node_count_q <= '0;
      overflow_q   <= 1'b0;
      range_err_q  <= 1'b0;
      node_limit_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      q_count_q    <= '0;
      visited_q    <= '0;
      node_q       <= '0;
      wait_cnt_q   <= '0;
      field_idx_q  <= '0;
      pack_q       <= '0;
      byte_cnt_q   <= '0;
      occ_data_q   <= '0;
      occ_valid_q  <= 1'b0;
      occ_last_q   <= 1'b0;
      occ_bytes_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      node_count_q <= node_count_d;
      overflow_q   <= overflow_d;
      range_err_q  <= range_err_d;
      node_limit_q <= node_limit_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      q_count_q    <= q_count_d;
      visited_q    <= visited_d;
      node_q       <= node_d;
      wait_cnt_q   <= wait_cnt_d;
      field_idx_q  <= field_idx_d;
      pack_q       <= pack_d;
      byte_cnt_q   <= byte_cnt_d;
      occ_data_q   <= occ_data_d;
      occ_valid_q  <= occ_valid_d;
      occ_last_q   <= occ_last_d;
      occ_bytes_q  <= occ_bytes_d;
    end
  end

  // Queue storage needs no reset: the occupancy count alone decides what is live.
  always_ff @(posedge i_clk) begin
    if (push_en) begin
      queue_mem_q[push_idx] <= push_addr;
    end
  end

  assign bus.o_bram_en   = state_q == S_FETCH;
  assign bus.o_bram_addr = (state_q == S_FETCH) ? queue_mem_q[head_q] : '0;
  assign bus.o_occ_data  = occ_data_q;
  assign bus.o_occ_valid = occ_valid_q;
  assign bus.o_occ_last  = occ_last_q;
  assign bus.o_occ_bytes = occ_bytes_q;

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_node_count = node_count_q;
  assign o_overflow   = overflow_q;
  assign o_range_err  = range_err_q;
endmodule

// File: tb/tb_octree_bfs_engine.sv
// Directed and randomized traversals of octree_bfs_engine, checked against a queue-based BFS model.
module tb_octree_bfs_engine;
  localparam int ADDR_W       = 9;
  localparam int PTR_W        = 16;
  localparam int NODE_W       = 152;
  localparam int QUEUE_DEPTH  = 4;
  localparam int BURST_W      = 64;
  localparam int BRAM_LATENCY = 1;
  localparam int ROOT_ADDR    = 2;
  localparam int BYTES        = BURST_W / 8;
  localparam int MAP_N        = 2 ** ADDR_W;
  localparam int FIELD_W      = 8 * PTR_W;
  localparam int MAX_CYCLES   = 4000;

  typedef struct {
    logic [BURST_W-1:0] data;
    int                 bytes;
    bit                 last;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] node_limit = '0;
  logic        busy, done, overflow, range_err;
  logic [15:0] node_count;

  int checks = 0;
  int errors = 0;

  logic [NODE_W-1:0] bram [MAP_N];
  logic [NODE_W-1:0] dout_q;

  burst_t     got[$];
  burst_t     exp_b[$];
  logic [7:0] exp_codes[$];
  int         exp_count;
  bit         exp_ovf, exp_rerr;

  octree_bfs_engine_if #(.ADDR_W(ADDR_W), .NODE_W(NODE_W), .BURST_W(BURST_W)) bus ();

  octree_bfs_engine #(
    .ADDR_W(ADDR_W), .PTR_W(PTR_W), .NODE_W(NODE_W), .QUEUE_DEPTH(QUEUE_DEPTH),
    .BURST_W(BURST_W), .BRAM_LATENCY(BRAM_LATENCY), .ROOT_ADDR(ROOT_ADDR)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_node_limit(node_limit),
    .bus(bus), .o_busy(busy), .o_done(done), .o_node_count(node_count),
    .o_overflow(overflow), .o_range_err(range_err)
  );

  always #5 clk = ~clk;

  // Single-cycle-latency BRAM model.
  always @(posedge clk) begin
    if (bus.o_bram_en) dout_q <= bram[bus.o_bram_addr];
  end
  assign bus.i_bram_dout = dout_q;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk(input logic [FIELD_W-1:0] f);
    logic [NODE_W-FIELD_W-1:0] junk;
    junk = (NODE_W - FIELD_W)'($urandom);
    return {f, junk};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < MAP_N; i++) bram[i] = '0;
  endtask

  // Reference: plain BFS over the table with a bounded queue and a visited set.
  task automatic run_model(input int limit);
    bit               vis[MAP_N];
    int               q[$];
    int               node;
    int               n;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       code;
    logic [BURST_W-1:0] acc;
    for (int i = 0; i < MAP_N; i++) vis[i] = 0;
    exp_codes.delete();
    exp_ovf = 0; exp_rerr = 0; exp_count = 0;
    q.push_back(ROOT_ADDR);
    vis[ROOT_ADDR] = 1;
    forever begin
      node = q.pop_front();
      code = '0;
      for (int j = 0; j < 8; j++) begin
        ptr = bram[node][NODE_W-1-j*PTR_W -: PTR_W];
        if (ptr != 0) code[7-j] = 1'b1;
      end
      exp_codes.push_back(code);
      if (exp_count < 65535) exp_count++;
      for (int j = 0; j < 8; j++) begin
        ptr = bram[node][NODE_W-1-j*PTR_W -: PTR_W];
        if (int'(ptr) >= MAP_N) exp_rerr = 1;
        else if (ptr >= 2 && !vis[ptr]) begin
          if (q.size() == QUEUE_DEPTH) exp_ovf = 1;
          else begin
            q.push_back(int'(ptr));
            vis[ptr] = 1;
          end
        end
      end
      if (q.size() == 0 || (limit != 0 && exp_count == limit)) break;
    end
    exp_b.delete();
    acc = '0; n = 0;
    foreach (exp_codes[i]) begin
      acc[BURST_W-1-8*n -: 8] = exp_codes[i];
      n++;
      if (n == BYTES) begin
        exp_b.push_back('{acc, BYTES, 1'b0});
        acc = '0; n = 0;
      end
    end
    exp_b.push_back('{acc, n, 1'b1});
  endtask

  // ready_mode: 0 always ready, 1 random ready, 2 ready low for 20 cycles after first valid.
  task automatic applyStimulus(input logic [15:0] limit, input int ready_mode);
    int     cyc, stall_cnt, nmin;
    bit     seen_valid, held, done_seen;
    burst_t hold_b;
    run_model(int'(limit));
    got.delete();
    @(posedge clk); #1;
    node_limit = limit;
    start = 1'b1;
    bus.i_occ_ready = (ready_mode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    node_limit = 16'($urandom);
    @(negedge clk);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    cyc = 0; stall_cnt = 0; seen_valid = 0; held = 0; done_seen = 0;
    while (cyc < MAX_CYCLES && !done_seen) begin
      if (bus.o_occ_valid) begin
        if (held) begin
          checkOutput("hold_data", bus.o_occ_data, hold_b.data);
          checkOutput("hold_bytes", 64'(bus.o_occ_bytes), 64'(hold_b.bytes));
          checkOutput("hold_last", 64'(bus.o_occ_last), 64'(hold_b.last));
        end
        seen_valid = 1;
        hold_b = '{bus.o_occ_data, int'(bus.o_occ_bytes), bus.o_occ_last};
        if (bus.i_occ_ready) begin
          got.push_back(hold_b);
          held = 0;
        end else held = 1;
      end else if (held) begin
        checkOutput("valid_dropped", 64'd0, 64'd1);
        held = 0;
      end
      if (done) done_seen = 1;
      else begin
        @(posedge clk); #1;
        case (ready_mode)
          0: bus.i_occ_ready = 1'b1;
          1: bus.i_occ_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (seen_valid) begin
              bus.i_occ_ready = (stall_cnt >= 20);
              stall_cnt++;
            end else bus.i_occ_ready = 1'b0;
          end
        endcase
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) checkOutput("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    checkOutput("done_pulse_width", 64'(done), 64'd0);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("burst_count", 64'(got.size()), 64'(exp_b.size()));
    nmin = (got.size() < exp_b.size()) ? got.size() : exp_b.size();
    for (int i = 0; i < nmin; i++) begin
      checkOutput($sformatf("burst%0d_data", i), got[i].data, exp_b[i].data);
      checkOutput($sformatf("burst%0d_bytes", i), 64'(got[i].bytes), 64'(exp_b[i].bytes));
      checkOutput($sformatf("burst%0d_last", i), 64'(got[i].last), 64'(exp_b[i].last));
    end
    checkOutput("node_count", 64'(node_count), 64'(exp_count));
    checkOutput("overflow", 64'(overflow), 64'(exp_ovf));
    checkOutput("range_err", 64'(range_err), 64'(exp_rerr));
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_node_count"}, 64'(node_count), 64'd0);
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
    checkOutput({tag, "_range_err"}, 64'(range_err), 64'd0);
    checkOutput({tag, "_bram_en"}, 64'(bus.o_bram_en), 64'd0);
    checkOutput({tag, "_bram_addr"}, 64'(bus.o_bram_addr), 64'd0);
    checkOutput({tag, "_occ_data"}, bus.o_occ_data, 64'd0);
    checkOutput({tag, "_occ_valid"}, 64'(bus.o_occ_valid), 64'd0);
    checkOutput({tag, "_occ_last"}, 64'(bus.o_occ_last), 64'd0);
    checkOutput({tag, "_occ_bytes"}, 64'(bus.o_occ_bytes), 64'd0);
  endtask

  task automatic load_nine_node_tree();
    clear_mem();
    bram[2]  = mk({16'd3, 16'd4, {6{16'd0}}});
    bram[3]  = mk({16'd5, 16'd6, {6{16'd0}}});
    bram[4]  = mk({16'd7, 16'd8, {6{16'd0}}});
    bram[5]  = mk({16'd9, {7{16'd0}}});
    bram[6]  = mk({16'd10, {7{16'd0}}});
    for (int a = 7; a <= 10; a++) bram[a] = mk({8{16'd1}});
  endtask

  task automatic load_test2_tree();
    clear_mem();
    bram[2] = mk({16'd3, 16'd4, {6{16'd0}}});
    bram[3] = mk({8{16'd1}});
    bram[4] = mk({8{16'd1}});
  endtask

  initial begin
    logic [FIELD_W-1:0] f;
    int                 r;
    logic [15:0]        lim;
    bus.i_occ_ready = 1'b0;
    clear_mem();
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] test 1: root of leaves");
    bram[2] = mk({8{16'd1}});
    applyStimulus(16'd0, 0);
    if (got.size() > 0) checkOutput("t1_literal_data", got[0].data, 64'hFF00_0000_0000_0000);

    $display("[TB] test 2: two leaf-only children");
    load_test2_tree();
    applyStimulus(16'd0, 0);
    if (got.size() > 0) checkOutput("t2_literal_data", got[0].data, 64'hC0FF_FF00_0000_0000);

    $display("[TB] test 3: duplicate pointers");
    clear_mem();
    bram[2] = mk({16'd3, 16'd3, 16'd3, {5{16'd0}}});
    bram[3] = mk({16'd2, 16'd1, {6{16'd0}}});
    applyStimulus(16'd0, 0);
    checkOutput("t3_literal_count", 64'(node_count), 64'd2);

    $display("[TB] test 4: queue overflow");
    clear_mem();
    bram[2] = mk({16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10});
    applyStimulus(16'd0, 0);
    checkOutput("t4_literal_overflow", 64'(overflow), 64'd1);

    $display("[TB] test 5: nine nodes with stalled sink");
    load_nine_node_tree();
    applyStimulus(16'd0, 2);
    if (got.size() > 1) checkOutput("t5_literal_last_bytes", 64'(got[1].bytes), 64'd1);

    $display("[TB] node limit and range error");
    load_nine_node_tree();
    applyStimulus(16'd4, 1);
    clear_mem();
    bram[2] = mk({16'd3, 16'd600, {6{16'd0}}});
    bram[3] = mk({8{16'd1}});
    applyStimulus(16'd0, 0);

    $display("[TB] test 6: reset mid-traversal");
    load_test2_tree();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(16'd0, 0);
    if (got.size() > 0) checkOutput("t6_literal_data", got[0].data, 64'hC0FF_FF00_0000_0000);

    $display("[TB] randomized trees");
    for (int t = 0; t < 8; t++) begin
      clear_mem();
      for (int a = 2; a < 16; a++) begin
        f = '0;
        for (int j = 0; j < 8; j++) begin
          r = $urandom_range(0, 19);
          if (r < 7)       f[FIELD_W-1-j*PTR_W -: PTR_W] = 16'd0;
          else if (r < 11) f[FIELD_W-1-j*PTR_W -: PTR_W] = 16'd1;
          else if (r < 19) f[FIELD_W-1-j*PTR_W -: PTR_W] = 16'($urandom_range(2, 15));
          else             f[FIELD_W-1-j*PTR_W -: PTR_W] = 16'($urandom_range(MAP_N, 65535));
        end
        bram[a] = mk(f);
      end
      lim = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 6)) : 16'd0;
      applyStimulus(lim, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
